// File: rtl/vram_planar.sv
// Planar video RAM: per-plane masked direct writes, registered read port and a range-fill engine.
// Optional VRAM_READ_BYPASS_EN forwards a same-cycle write to the read port; default is read-before-write.
module vram_planar #(
  parameter int PLANES  = 2,
  parameter int PLANE_W = 4,
  parameter int ADDR_W  = 13
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_W-1:0]         raddr,
  output logic [PLANES*PLANE_W-1:0] rdata,
  input  logic                      wr,
  input  logic [ADDR_W-1:0]         waddr,
  input  logic [PLANES*PLANE_W-1:0] wdata,
  input  logic [PLANES-1:0]         wmask,
  input  logic                      fill_start,
  input  logic [ADDR_W-1:0]         fill_base,
  input  logic [ADDR_W:0]           fill_len,
  input  logic [PLANES*PLANE_W-1:0] fill_value,
  input  logic [PLANES-1:0]         fill_mask,
  output logic                      fill_busy,
  output logic                      fill_done
);

  // state | meaning
  // IDLE  | waiting for fill_start
  // FILL  | writing one word per non-stalled cycle
  // DONE  | fill_done pulse, back to IDLE next cycle
  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

  localparam int DEPTH = 1 << ADDR_W;
  localparam int DW    = PLANES * PLANE_W;

  state_t              state;
  logic [ADDR_W-1:0]   cur;
  logic [ADDR_W:0]     remaining;
  logic [DW-1:0]       fval;
  logic [PLANES-1:0]   fmask;

  logic                we;
  logic [ADDR_W-1:0]   wa;
  logic [DW-1:0]       wd;
  logic [PLANES-1:0]   wm;

  // Single shared write port; a direct write always wins over the fill engine.
  always_comb begin
    we = 1'b0;
    wa = waddr;
    wd = wdata;
    wm = wmask;
    if (wr) begin
      we = 1'b1;
    end else if (state == S_FILL) begin
      we = 1'b1;
      wa = cur;
      wd = fval;
      wm = fmask;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cur       <= '0;
      remaining <= '0;
      fval      <= '0;
      fmask     <= '0;
      fill_busy <= 1'b0;
      fill_done <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          fill_done <= 1'b0;
          if (fill_start) begin
            fval      <= fill_value;
            fmask     <= fill_mask;
            cur       <= fill_base;
            remaining <= fill_len;
            fill_busy <= 1'b1;
            if (fill_len == '0) begin
              state     <= S_DONE;
              fill_done <= 1'b1;
            end else begin
              state <= S_FILL;
            end
          end
        end
        S_FILL: begin
          if (!wr) begin
            cur       <= cur + 1'b1;
            remaining <= remaining - 1'b1;
            if (remaining == (ADDR_W+1)'(1)) begin
              state     <= S_DONE;
              fill_done <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state     <= S_IDLE;
          fill_done <= 1'b0;
          fill_busy <= 1'b0;
        end
        default: begin
          state     <= S_IDLE;
          fill_done <= 1'b0;
          fill_busy <= 1'b0;
        end
      endcase
    end
  end

  for (genvar p = 0; p < PLANES; p++) begin : g_plane
    logic [PLANE_W-1:0] mem [DEPTH];
    logic [PLANE_W-1:0] rd_next;
    logic [PLANE_W-1:0] rd_q;

    always_ff @(posedge clk) begin
      if (we && wm[p]) mem[wa] <= wd[p*PLANE_W +: PLANE_W];
    end

    always_comb begin
      rd_next = mem[raddr];
`ifdef VRAM_READ_BYPASS_EN
      if (we && wm[p] && (wa == raddr)) rd_next = wd[p*PLANE_W +: PLANE_W];
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) rd_q <= '0;
      else     rd_q <= rd_next;
    end

    assign rdata[p*PLANE_W +: PLANE_W] = rd_q;
  end

endmodule

// File: tb/tb_vram_planar.sv
// Directed + randomized bench for vram_planar against an array-based reference memory.
module tb_vram_planar;
  localparam int AW    = 13;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] raddr;
  logic [7:0]    rdata;
  logic          wr;
  logic [AW-1:0] waddr;
  logic [7:0]    wdata;
  logic [1:0]    wmask;
  logic          fill_start;
  logic [AW-1:0] fill_base;
  logic [AW:0]   fill_len;
  logic [7:0]    fill_value;
  logic [1:0]    fill_mask;
  logic          fill_busy;
  logic          fill_done;

  vram_planar #(.PLANES(2), .PLANE_W(4), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata),
    .wr(wr), .waddr(waddr), .wdata(wdata), .wmask(wmask),
    .fill_start(fill_start), .fill_base(fill_base), .fill_len(fill_len),
    .fill_value(fill_value), .fill_mask(fill_mask),
    .fill_busy(fill_busy), .fill_done(fill_done)
  );

  always #5 clk = ~clk;

  logic [7:0] ref_mem [DEPTH];
  int vectors = 0;
  int miscompares = 0;

  function automatic logic [7:0] merge(input logic [7:0] old, input logic [7:0] d, input logic [1:0] m);
    logic [7:0] r;
    r = old;
    if (m[0]) r[3:0] = d[3:0];
    if (m[1]) r[7:4] = d[7:4];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input int a, input logic [7:0] d, input logic [1:0] m);
    @(negedge clk);
    wr = 1'b1; waddr = AW'(a); wdata = d; wmask = m;
    @(negedge clk);
    wr = 1'b0;
    ref_mem[a % DEPTH] = merge(ref_mem[a % DEPTH], d, m);
  endtask

  task automatic check_read(input int a, input string tag);
    @(negedge clk);
    raddr = AW'(a);
    @(negedge clk);
    chk(tag, 32'(rdata), 32'(ref_mem[a % DEPTH]));
  endtask

  // stall_at: index (1..len) of the fill cycle during which a direct write to saddr is issued; 0 = none.
  task automatic run_fill(input int base, input int len, input logic [7:0] val, input logic [1:0] msk,
                          input int stall_at, input int saddr, input logic [7:0] sdata, input bit poke);
    int seen;
    int exp_done;
    seen = -1;
    exp_done = len + ((stall_at > 0 && stall_at <= len) ? 1 : 0);
    @(negedge clk);
    fill_start = 1'b1; fill_base = AW'(base); fill_len = (AW+1)'(len);
    fill_value = val; fill_mask = msk;
    @(negedge clk);
    // Scramble the fill inputs; the engine must use the values latched at accept.
    fill_start = poke;
    fill_base  = AW'($urandom);
    fill_len   = (AW+1)'($urandom_range(1, 9));
    fill_value = ~val;
    fill_mask  = 2'($urandom);
    for (int k = 0; k <= len + 4; k++) begin
      if (k > 0) begin
        if (k == stall_at) begin
          wr = 1'b1; waddr = AW'(saddr); wdata = sdata; wmask = 2'b11;
        end
        @(negedge clk);
        wr = 1'b0;
        if (k == 1) fill_start = 1'b0;
      end
      chk("fill_busy_during", 32'(fill_busy), 32'd1);
      if (fill_done === 1'b1) begin
        seen = k;
        break;
      end
    end
    fill_start = 1'b0;
    chk("fill_done_cycle", 32'(seen), 32'(exp_done));
    @(negedge clk);
    chk("fill_busy_after", 32'(fill_busy), 32'd0);
    chk("fill_done_after", 32'(fill_done), 32'd0);
    @(negedge clk);
    chk("no_queued_fill", 32'(fill_busy), 32'd0);
    for (int i = 0; i < len; i++)
      ref_mem[(base + i) % DEPTH] = merge(ref_mem[(base + i) % DEPTH], val, msk);
    if (stall_at > 0 && stall_at <= len)
      ref_mem[saddr % DEPTH] = sdata;
  endtask

  initial begin
    logic [7:0] exp_byp;
    int b, l, st;
    rst = 1'b1; raddr = '0; wr = 1'b0; waddr = '0; wdata = '0; wmask = '0;
    fill_start = 1'b0; fill_base = '0; fill_len = '0; fill_value = '0; fill_mask = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
    @(negedge clk);
    @(negedge clk);
    chk("reset_rdata", 32'(rdata), 32'd0);
    chk("reset_busy", 32'(fill_busy), 32'd0);
    chk("reset_done", 32'(fill_done), 32'd0);
    rst = 1'b0;

    // Full-memory clear (len = 2^ADDR_W) establishes known contents.
    run_fill(0, DEPTH, 8'h00, 2'b11, 0, 0, 8'h00, 1'b0);
    check_read(0, "clear_first");
    check_read(DEPTH - 1, "clear_last");
    check_read(4321, "clear_mid");

    // Masked direct writes.
    do_write(16'h0010, 8'hA5, 2'b01);
    check_read(16'h0010, "wmask_lo");
    do_write(16'h0010, 8'h3C, 2'b10);
    check_read(16'h0010, "wmask_hi");
    chk("wmask_combined", 32'(ref_mem[16'h0010]), 32'h35);
    do_write(16'h0010, 8'hFF, 2'b00);
    check_read(16'h0010, "wmask_none");

    // Basic fill, len = 4.
    run_fill(16'h0100, 4, 8'h7E, 2'b11, 0, 0, 8'h00, 1'b0);
    for (int a = 16'h00FF; a <= 16'h0104; a++) check_read(a, "fill4");

    // Stall on the second fill cycle.
    run_fill(16'h0400, 3, 8'hC3, 2'b11, 2, 16'h0500, 8'h11, 1'b0);
    for (int a = 16'h0400; a <= 16'h0403; a++) check_read(a, "fill_stall");
    check_read(16'h0500, "stall_write");

    // Wrap, zero length, start-while-busy ignored.
    run_fill(DEPTH - 1, 2, 8'h96, 2'b11, 0, 0, 8'h00, 1'b0);
    check_read(DEPTH - 2, "wrap_below");
    check_read(DEPTH - 1, "wrap_top");
    check_read(0, "wrap_zero");
    check_read(1, "wrap_after");
    run_fill(16'h0700, 0, 8'hEE, 2'b11, 0, 0, 8'h00, 1'b0);
    check_read(16'h0700, "len0_nochange");
    run_fill(16'h0800, 6, 8'h5C, 2'b01, 0, 0, 8'h00, 1'b1);
    for (int a = 16'h0800; a <= 16'h0806; a++) check_read(a, "fill_poke");

    // Reset asserted during the third write of a len=8 fill.
    @(negedge clk);
    fill_start = 1'b1; fill_base = 13'h0300; fill_len = 14'd8; fill_value = 8'h6B; fill_mask = 2'b11;
    @(negedge clk);
    fill_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_busy", 32'(fill_busy), 32'd0);
    chk("rst_mid_done", 32'(fill_done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ref_mem[16'h0300] = 8'h6B;
    ref_mem[16'h0301] = 8'h6B;
    @(negedge clk);
    chk("rst_post_done", 32'(fill_done), 32'd0);
    for (int a = 16'h0300; a <= 16'h0308; a++) check_read(a, "rst_mid_fill");
    run_fill(16'h0310, 3, 8'h24, 2'b10, 0, 0, 8'h00, 1'b0);
    for (int a = 16'h0310; a <= 16'h0313; a++) check_read(a, "fill_after_rst");

    // Same-cycle write and read of one address.
    @(negedge clk);
    wr = 1'b1; waddr = 13'h0020; wdata = 8'h5A; wmask = 2'b11; raddr = 13'h0020;
`ifdef VRAM_READ_BYPASS_EN
    exp_byp = 8'h5A;
`else
    exp_byp = ref_mem[16'h0020];
`endif
    @(negedge clk);
    wr = 1'b0;
    chk("same_cycle_rw", 32'(rdata), 32'(exp_byp));
    ref_mem[16'h0020] = 8'h5A;
    check_read(16'h0020, "after_rw");

    // Randomized mix.
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 2))
        0: begin
          b = $urandom_range(0, DEPTH - 1);
          do_write(b, 8'($urandom), 2'($urandom));
          check_read(b, "rand_write");
        end
        1: check_read($urandom_range(0, DEPTH - 1), "rand_read");
        default: begin
          b  = $urandom_range(0, DEPTH - 1);
          l  = $urandom_range(0, 12);
          st = $urandom_range(0, l);
          run_fill(b, l, 8'($urandom), 2'($urandom), st, (b + 100) % DEPTH, 8'($urandom), 1'($urandom));
          for (int i = 0; i <= l; i++) check_read((b + i) % DEPTH, "rand_fill");
          if (st > 0) check_read((b + 100) % DEPTH, "rand_stall");
        end
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vram_planar.md
# vram_planar

Parametrised planar video RAM with a built-in hardware fill engine. The block is the next generation of the two-plane 4-bit VRAM:
- It generalises plane count, plane width and depth.
- It adds per-plane write masking.
- It adds a sequential fill engine that clears or paints an address range with a constant value.

It sits between the CPU/blitter write side and the pixel fetch path of the graphics pipeline. The pixel fetch path uses the independent registered read port.

## Interface
- PLANES, 2, number of independent bit-planes
- PLANE_W, 4, bits per plane
- ADDR_W, 13, address width; depth = 2^ADDR_W words
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- raddr  in  ADDR_W  read address
- rdata  out  PLANES*PLANE_W  registered read data, plane p at bits [p*PLANE_W +: PLANE_W]
- wr  in  1  direct write strobe
- waddr  in  ADDR_W  direct write address
- wdata  in  PLANES*PLANE_W  direct write data
- wmask  in  PLANES  per-plane write enable for direct write
- fill_start  in  1  start fill (accepted only when fill_busy=0)
- fill_base  in  ADDR_W  first fill address
- fill_len  in  ADDR_W+1  number of words to fill (0 to 2^ADDR_W)
- fill_value  in  PLANES*PLANE_W  fill data
- fill_mask  in  PLANES  per-plane enable for fill writes
- fill_busy  out  1  fill engine not idle
- fill_done  out  1  one-cycle pulse on fill completion

## Operation
- Memory array: PLANES separate arrays of 2^ADDR_W x PLANE_W. Contents are not reset.
- Direct write: when wr=1, plane p at waddr is written with its slice of wdata iff wmask[p]=1. wmask=0 makes the write a no-op.
- Fill FSM states: IDLE, FILL, DONE. fill_busy = (state != IDLE).
- IDLE:
  - fill_start=1 latches base, len, value and mask into internal registers.
  - len=0 → DONE. Otherwise → FILL, with cur=base and remaining=len.
- FILL:
  - Each cycle with wr=0: write fill_value to cur on planes enabled by the latched mask, then cur=cur+1 mod 2^ADDR_W and remaining=remaining-1.
  - The write that brings remaining to 0 moves the FSM to DONE.
  - Cycles with wr=1: direct write has priority. The fill stalls and cur and remaining hold.
- DONE: fill_done=1 for exactly this cycle, then → IDLE.
- fill_start while fill_busy=1 is ignored. It is not queued.
- Fill input ports are sampled only at the accepting edge. Later changes on them have no effect on a fill in progress.
- Address wrap: fill_base=2^ADDR_W-1 with len=2 writes the top address, then address 0.
- len=2^ADDR_W fills the entire memory.
- Reset mid-fill: FSM returns to IDLE immediately and the fill is aborted. Already-written words keep their fill data. Neither fill_done nor any further write occurs.

## Timing
- Reset values: rdata=0, fill_busy=0, fill_done=0, FSM=IDLE, cur=0, remaining=0.
- Read latency: 1 cycle. rdata at edge n+1 reflects raddr at edge n.
- Write latency: a write presented at edge n is visible to a read issued at edge n+1.
- Fill duration with no stalls is len+2 cycles from the accepting edge to fill_done falling:
  - the accept cycle;
  - len write cycles;
  - the DONE cycle.
  - With len=0 the duration is 2 cycles.
- Each stall cycle (wr=1 during FILL) adds exactly 1 cycle.
- fill_busy rises the cycle after fill_start is accepted and falls the cycle after fill_done.
- The read port is never stalled by writes or fills.

## Configuration
- VRAM_READ_BYPASS_EN defined:
  - A read at the same address as the write committed in the same cycle returns the new data for written planes. Either a direct write or a fill write counts.
  - Unwritten planes return the stored data.
  - The forwarding mux is combinational, and rdata stays registered.
- Undefined: a same-cycle same-address read returns the old (pre-write) data on all planes (read-before-write).

## Test plan
- Default params: wr=1, waddr=0x0010, wdata=0xA5, wmask=2'b01; then read 0x0010 → rdata=0x?5 with upper nibble unchanged from its prior value. A second write of 0x3C with wmask=2'b10 → read returns 0x35.
- Fill of base=0x0100, len=4, value=0x7E, mask=2'b11, no stalls:
  - fill_busy is high for 5 cycles;
  - fill_done pulses once at cycle 6 after start;
  - addresses 0x0100-0x0103 read 0x7E and 0x0104 is unchanged.
- Fill of len=3 with wr=1 asserted on the 2nd fill cycle (waddr=0x0500, wdata=0x11, wmask=2'b11): done is delayed by 1 cycle, 0x0500 reads 0x11, and all 3 fill words are written.
- Wrap and degenerate cases:
  - fill_base=0x1FFF, len=2 → 0x1FFF and 0x0000 are filled.
  - len=0 → fill_done 2 cycles after start with no memory change.
  - fill_start during busy is ignored.
- Assert rst on the 3rd write of a len=8 fill: the first 2 words are filled and the rest unchanged. fill_busy=0 and fill_done=0 immediately. A new fill after release works.
- Same-cycle write 0x5A to 0x0020 and read 0x0020 (old value 0x00): with VRAM_READ_BYPASS_EN, rdata=0x5A next cycle; without it, rdata=0x00.
